// File: rtl/serial_tx_framer_if.sv
// Bundles the producer-side controls and status of the serial framer.
// Pure wiring: no storage, no added latency.
// Status outputs are the only feedback; the producer watches HoldFull/SampleErr.
interface serial_tx_framer_if #(
  parameter int WIDTH = 32,
  parameter int DIV_W = 16
);
  logic [WIDTH-1:0] DataIn;
  logic             Sample;
  logic             StartTx;
  logic             Abort;
  logic [DIV_W-1:0] BitDiv;
  logic             Dout;
  logic             TxBusy;
  logic             TxDone;
  logic             HoldFull;
  logic             SampleErr;

  modport master (
    output DataIn, Sample, StartTx, Abort, BitDiv,
    input  Dout, TxBusy, TxDone, HoldFull, SampleErr
  );

  modport slave (
    input  DataIn, Sample, StartTx, Abort, BitDiv,
    output Dout, TxBusy, TxDone, HoldFull, SampleErr
  );
endinterface

// File: rtl/serial_tx_framer.sv
// Serial framer: start, WIDTH data bits, optional parity, stop; divider-derived bit rate.
// Start bit on Dout one clock after an accepted StartTx; each bit lasts BitDiv+1 clocks.
// One-word holding buffer; a Sample into a full, non-draining buffer is dropped with SampleErr.
module serial_tx_framer #(
  parameter int WIDTH      = 32,
  parameter int DIV_W      = 16,
  parameter bit LSB_FIRST  = 1'b0,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0,
  parameter bit IDLE_LVL   = 1'b1
) (
  input logic Clk,
  input logic Reset,
  serial_tx_framer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] divcnt;
  logic [DIV_W-1:0] div_lat;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             pending;
  logic             par;
  logic             dout;
  logic             txbusy;
  logic             txdone;
  logic             sample_err;

  logic             div_tc;
  logic             stop_end;
  logic             go_idle_start;
  logic             go_b2b;
  logic             frame_go;
  logic             hold_xfer;
  logic [WIDTH-1:0] load_word;

  // A frame launches from IDLE on StartTx if the holding buffer is full or a word
  // bypasses it this cycle; at the end of STOP it relaunches only from the buffer.
  always_comb begin
    div_tc        = (divcnt == div_lat);
    stop_end      = (state == STOP) && div_tc && !bus.Abort;
    go_idle_start = (state == IDLE) && bus.StartTx && !bus.Abort && (hold_full || bus.Sample);
    go_b2b        = stop_end && (pending || bus.StartTx) && hold_full;
    frame_go      = go_idle_start || go_b2b;
    hold_xfer     = frame_go && hold_full;
    load_word     = hold_full ? hold : bus.DataIn;
  end

  // Holding buffer: fill when empty, refill on the cycle it drains, otherwise flag the drop.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hold       <= '0;
      hold_full  <= 1'b0;
      sample_err <= 1'b0;
    end else begin
      sample_err <= 1'b0;
      if (bus.Sample) begin
        if (!hold_full) begin
          // When the word bypasses straight into the shifter the buffer stays empty.
          if (!go_idle_start) begin
            hold      <= bus.DataIn;
            hold_full <= 1'b1;
          end
        end else if (hold_xfer) begin
          hold <= bus.DataIn;
        end else begin
          sample_err <= 1'b1;
        end
      end else if (hold_xfer) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      divcnt  <= '0;
      div_lat <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      pending <= 1'b0;
      par     <= 1'b0;
      dout    <= IDLE_LVL;
      txbusy  <= 1'b0;
      txdone  <= 1'b0;
    end else begin
      txdone <= 1'b0;
      if (state != IDLE) begin
        if (bus.Abort) begin
          state   <= IDLE;
          dout    <= IDLE_LVL;
          txbusy  <= 1'b0;
          pending <= 1'b0;
        end else begin
          if (bus.StartTx) pending <= 1'b1;
          if (!div_tc) begin
            divcnt <= divcnt + DIV_W'(1);
          end else begin
            divcnt <= '0;
            case (state)
              START: begin
                state <= DATA;
                dout  <= LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
              end
              DATA: begin
                if (bitcnt == LAST_BIT) begin
                  bitcnt <= '0;
                  if (PARITY_EN) begin
                    state <= PARITY;
                    dout  <= par;
                  end else begin
                    state <= STOP;
                    dout  <= IDLE_LVL;
                  end
                end else begin
                  bitcnt <= bitcnt + CW'(1);
                  if (LSB_FIRST) begin
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                    dout  <= shreg[1];
                  end else begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    dout  <= shreg[WIDTH-2];
                  end
                end
              end
              PARITY: begin
                state <= STOP;
                dout  <= IDLE_LVL;
              end
              STOP: begin
                // Back-to-back relaunch is applied below and overrides this return to idle.
                txdone  <= 1'b1;
                state   <= IDLE;
                txbusy  <= 1'b0;
                pending <= 1'b0;
              end
              default: begin
                state <= IDLE;
                dout  <= IDLE_LVL;
              end
            endcase
          end
        end
      end
      // Frame launch: divisor and word are latched here so later input changes do not disturb the frame.
      if (frame_go) begin
        state   <= START;
        dout    <= ~IDLE_LVL;
        txbusy  <= 1'b1;
        divcnt  <= '0;
        bitcnt  <= '0;
        div_lat <= bus.BitDiv;
        shreg   <= load_word;
        par     <= PARITY_ODD ? ~^load_word : ^load_word;
        pending <= 1'b0;
      end
    end
  end

  assign bus.Dout      = dout;
  assign bus.TxBusy    = txbusy;
  assign bus.TxDone    = txdone;
  assign bus.HoldFull  = hold_full;
  assign bus.SampleErr = sample_err;

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer: a frame table for the MSB-first/even-parity
// build, hand sequences for back-to-back, buffer overflow, abort and reset, and an
// LSB-first/no-parity build for bit ordering.
module tb_serial_tx_framer;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_bad;

  serial_tx_framer_if #(.WIDTH(8), .DIV_W(8)) if0 ();
  serial_tx_framer_if #(.WIDTH(8), .DIV_W(8)) if1 ();

  serial_tx_framer #(
    .WIDTH(8), .DIV_W(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .IDLE_LVL(1'b1)
  ) u0 (
    .Clk(Clk), .Reset(Reset), .bus(if0)
  );

  serial_tx_framer #(
    .WIDTH(8), .DIV_W(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .IDLE_LVL(1'b1)
  ) u1 (
    .Clk(Clk), .Reset(Reset), .bus(if1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  div;
    logic [10:0] exp;   // line bits, exp[10] sent first: start, d7..d0, parity, stop
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (if0.TxBusy && n < 500) begin
      @(negedge Clk);
      n++;
    end
    if (if0.TxBusy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: TxBusy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  // Launch one table frame through the bypass path and check every bit period.
  task automatic send_vec(input vec_t v, input int idx);
    int p;
    int busy_n;
    int done_n;
    logic [10:0] e;
    p = int'(v.div) + 1;
    e = v.exp;
    wait_idle0();
    if0.DataIn  = v.data;
    if0.BitDiv  = v.div;
    if0.Sample  = 1'b1;
    if0.StartTx = 1'b1;
    @(negedge Clk);
    if0.Sample  = 1'b0;
    if0.StartTx = 1'b0;
    if0.BitDiv  = 8'd7;      // mid-frame divisor change must be ignored
    busy_n = 0;
    done_n = 0;
    for (int off = 0; off <= 11 * p; off++) begin
      if (off > 0) @(negedge Clk);
      if ((off % p) == 0 && (off / p) <= 10)
        chk($sformatf("vec%0d_bit%0d", idx, off / p), if0.Dout, e[10 - off / p]);
      if (if0.TxBusy) busy_n++;
      if (if0.TxDone) done_n++;
      if (off == 11 * p) begin
        chk($sformatf("vec%0d_done_at_end", idx), if0.TxDone, 1);
        chk($sformatf("vec%0d_busy_fall", idx), if0.TxBusy, 0);
      end
    end
    chk($sformatf("vec%0d_busy_cycles", idx), busy_n, 11 * p);
    chk($sformatf("vec%0d_done_count", idx), done_n, 1);
  endtask

  initial begin
    logic [21:0] got22;
    logic [10:0] got11;
    logic [9:0]  got10;
    int          done_n;
    int          busy_n;

    n_cmp = 0;
    n_bad = 0;
    if0.DataIn = '0; if0.Sample = 0; if0.StartTx = 0; if0.Abort = 0; if0.BitDiv = '0;
    if1.DataIn = '0; if1.Sample = 0; if1.StartTx = 0; if1.Abort = 0; if1.BitDiv = '0;

    vt[0] = '{8'hA5, 8'd3, 11'b0_10100101_0_1};
    vt[1] = '{8'h00, 8'd0, 11'b0_00000000_0_1};
    vt[2] = '{8'hFF, 8'd1, 11'b0_11111111_0_1};
    vt[3] = '{8'h01, 8'd2, 11'b0_00000001_1_1};
    vt[4] = '{8'h80, 8'd0, 11'b0_10000000_1_1};
    vt[5] = '{8'h7E, 8'd1, 11'b0_01111110_0_1};

    // Reset state
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #1;
    chk("rst_dout", if0.Dout, 1);
    chk("rst_busy", if0.TxBusy, 0);
    chk("rst_done", if0.TxDone, 0);
    chk("rst_holdfull", if0.HoldFull, 0);
    chk("rst_sampleerr", if0.SampleErr, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // StartTx with nothing to send is dropped and leaves no pending request
    if0.StartTx = 1'b1;
    @(negedge Clk);
    if0.StartTx = 1'b0;
    chk("nodata_busy", if0.TxBusy, 0);
    if0.DataIn = 8'h5A;
    if0.Sample = 1'b1;
    @(negedge Clk);
    if0.Sample = 1'b0;
    chk("nodata_holdfull", if0.HoldFull, 1);
    @(negedge Clk);
    chk("nodata_no_autostart", if0.TxBusy, 0);
    if0.StartTx = 1'b1;
    @(negedge Clk);
    if0.StartTx = 1'b0;
    chk("hold_start_busy", if0.TxBusy, 1);
    chk("hold_start_dout", if0.Dout, 0);
    chk("hold_start_drained", if0.HoldFull, 0);
    wait_idle0();
    @(negedge Clk);

    // Table of single frames
    for (int i = 0; i < 6; i++) send_vec(vt[i], i);

    // Back-to-back: 0x3C then 0xC3 queued mid-frame, no idle gap
    wait_idle0();
    if0.BitDiv = 8'd0; if0.DataIn = 8'h3C; if0.Sample = 1; if0.StartTx = 1;
    @(negedge Clk);
    if0.Sample = 0; if0.StartTx = 0;
    done_n = 0;
    got22 = '0;
    for (int off = 0; off <= 22; off++) begin
      if (off > 0) @(negedge Clk);
      if (off < 22) got22[21 - off] = if0.Dout;
      if (if0.TxDone) done_n++;
      if (off == 3) begin if0.DataIn = 8'hC3; if0.Sample = 1; if0.StartTx = 1; end
      if (off == 4) begin
        if0.Sample = 0; if0.StartTx = 0;
        chk("b2b_holdfull", if0.HoldFull, 1);
      end
      if (off == 11) begin
        chk("b2b_first_done", if0.TxDone, 1);
        chk("b2b_busy_kept", if0.TxBusy, 1);
        chk("b2b_hold_drained", if0.HoldFull, 0);
      end
      if (off == 22) chk("b2b_busy_fall", if0.TxBusy, 0);
    end
    chk("b2b_line", got22, 22'b0_00111100_0_1_0_11000011_0_1);
    chk("b2b_done_count", done_n, 2);

    // Overflow: 0x77 dropped while full; refill accepted on the transfer cycle
    wait_idle0();
    if0.DataIn = 8'h11; if0.Sample = 1; if0.StartTx = 1;
    @(negedge Clk);
    if0.Sample = 0; if0.StartTx = 0;
    got11 = '0;
    for (int off = 0; off <= 22; off++) begin
      if (off > 0) @(negedge Clk);
      if (off >= 11 && off < 22) got11[21 - off] = if0.Dout;
      case (off)
        1: begin if0.DataIn = 8'h22; if0.Sample = 1; if0.StartTx = 1; end
        2: begin
          chk("ovf_accept_full", if0.HoldFull, 1);
          chk("ovf_accept_noerr", if0.SampleErr, 0);
          if0.DataIn = 8'h77; if0.StartTx = 0;
        end
        3: begin
          chk("ovf_err_pulse", if0.SampleErr, 1);
          chk("ovf_err_full", if0.HoldFull, 1);
          if0.Sample = 0;
        end
        4: chk("ovf_err_one_cycle", if0.SampleErr, 0);
        10: begin if0.DataIn = 8'h5A; if0.Sample = 1; end
        11: begin
          chk("xfer_noerr", if0.SampleErr, 0);
          chk("xfer_full", if0.HoldFull, 1);
          chk("xfer_done", if0.TxDone, 1);
          if0.Sample = 0;
        end
        22: chk("ovf_busy_fall", if0.TxBusy, 0);
        default: ;
      endcase
    end
    chk("ovf_kept_old_word", got11, 11'b0_00100010_0_1);
    chk("xfer_word_waiting", if0.HoldFull, 1);
    if0.StartTx = 1;
    @(negedge Clk);
    if0.StartTx = 0;
    for (int off = 0; off < 11; off++) begin
      if (off > 0) @(negedge Clk);
      got11[10 - off] = if0.Dout;
    end
    chk("xfer_word_line", got11, 11'b0_01011010_0_1);

    // Abort during data bit 3
    wait_idle0();
    if0.DataIn = 8'hA5; if0.Sample = 1; if0.StartTx = 1;
    @(negedge Clk);
    if0.Sample = 0; if0.StartTx = 0;
    @(negedge Clk);
    if0.DataIn = 8'h99; if0.Sample = 1;
    @(negedge Clk);
    if0.Sample = 0;
    repeat (2) @(negedge Clk);
    chk("abort_bit3_dout", if0.Dout, 0);
    if0.Abort = 1;
    @(negedge Clk);
    chk("abort_dout", if0.Dout, 1);
    chk("abort_busy", if0.TxBusy, 0);
    chk("abort_holdfull", if0.HoldFull, 1);
    chk("abort_no_done", if0.TxDone, 0);
    if0.StartTx = 1;
    @(negedge Clk);
    chk("abort_beats_start", if0.TxBusy, 0);
    if0.Abort = 0; if0.StartTx = 0;
    done_n = 0;
    repeat (15) begin
      @(negedge Clk);
      if (if0.TxDone) done_n++;
    end
    chk("abort_done_count", done_n, 0);
    chk("abort_hold_still_full", if0.HoldFull, 1);
    if0.StartTx = 1;
    @(negedge Clk);
    if0.StartTx = 0;
    chk("post_abort_start", if0.TxBusy, 1);
    chk("post_abort_drained", if0.HoldFull, 0);
    wait_idle0();

    // Reset asserted mid-frame
    if0.BitDiv = 8'd2; if0.DataIn = 8'h3C; if0.Sample = 1; if0.StartTx = 1;
    @(negedge Clk);
    if0.Sample = 0; if0.StartTx = 0;
    @(negedge Clk);
    if0.DataIn = 8'h44; if0.Sample = 1;
    @(negedge Clk);
    if0.Sample = 0;
    repeat (4) @(negedge Clk);
    chk("prerst_busy", if0.TxBusy, 1);
    chk("prerst_holdfull", if0.HoldFull, 1);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_dout", if0.Dout, 1);
    chk("midrst_busy", if0.TxBusy, 0);
    chk("midrst_holdfull", if0.HoldFull, 0);
    @(negedge Clk);
    Reset = 1'b1;
    done_n = 0;
    busy_n = 0;
    repeat (40) begin
      @(negedge Clk);
      if (if0.TxDone) done_n++;
      if (if0.TxBusy) busy_n++;
    end
    chk("midrst_done_count", done_n, 0);
    chk("midrst_busy_count", busy_n, 0);

    // LSB first, no parity, one bit per clock
    if1.BitDiv = 8'd0; if1.DataIn = 8'h01; if1.Sample = 1; if1.StartTx = 1;
    @(negedge Clk);
    if1.Sample = 0; if1.StartTx = 0;
    got10 = '0;
    done_n = 0;
    for (int off = 0; off <= 10; off++) begin
      if (off > 0) @(negedge Clk);
      if (off < 10) got10[9 - off] = if1.Dout;
      if (if1.TxDone) done_n++;
      if (off == 10) begin
        chk("lsb_done_at_end", if1.TxDone, 1);
        chk("lsb_busy_fall", if1.TxBusy, 0);
      end
    end
    chk("lsb_line", got10, 10'b0_10000000_1);
    chk("lsb_done_count", done_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
